// File: rtl/block_mean_pkg.sv
// Shared sizing helpers for the multi-channel block averager.
// Pure functions only, with no state, latency or flow control of their own.
package block_mean_pkg;

  function automatic int acc_w(input int width, input int log2n_max);
    return width + log2n_max;
  endfunction

  function automatic int ch_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic int clamp_log2n(input int req, input int log2n_max);
    return (req > log2n_max) ? log2n_max : req;
  endfunction

endpackage

// File: rtl/mean_round_shift.sv
// Combinational block-sum to mean conversion: optional round-half-up, shift by L, truncate.
// Zero latency and no flow control; the result follows the inputs.
module mean_round_shift #(
  parameter int WIDTH     = 32,
  parameter int ACC_W     = 40,
  parameter int LOG2N_MAX = 8,
  parameter int SIGNED    = 1,
  parameter int ROUND     = 1
) (
  input  logic [ACC_W-1:0]                 total_i,
  input  logic [$clog2(LOG2N_MAX+1)-1:0]   log2n_i,
  output logic [WIDTH-1:0]                 mean_o
);

  // One guard bit so the rounding add cannot wrap even at full-scale sums.
  localparam int SW = ACC_W + 1;

  logic [SW-1:0]        rnd;
  logic signed [SW-1:0] sum;

  always_comb begin
    rnd = '0;
    if (ROUND != 0 && log2n_i != '0) begin
      rnd = SW'(1) << (log2n_i - 1'b1);
    end
    if (SIGNED != 0) begin
      sum    = $signed({total_i[ACC_W-1], total_i}) + $signed(rnd);
      mean_o = WIDTH'(sum >>> log2n_i);
    end else begin
      sum    = $signed({1'b0, total_i} + rnd);
      mean_o = WIDTH'($unsigned(sum) >> log2n_i);
    end
  end

endmodule

// File: rtl/block_mean_mc.sv
// Per-channel block averager: emits the mean of every 2^L samples of a channel.
// One cycle from completing sample to o_vld; no backpressure, results are single-cycle pulses.
module block_mean_mc
  import block_mean_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CHANNELS  = 4,
  parameter int LOG2N_MAX = 8,
  parameter int SIGNED    = 1,
  parameter int ROUND     = 1
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [$clog2(LOG2N_MAX+1)-1:0]     i_log2n,
  input  logic                               i_clear,
  input  logic                               i_vld,
  input  logic [ch_w(CHANNELS)-1:0]          i_ch,
  input  logic [WIDTH-1:0]                   i_data,
  output logic                               o_vld,
  output logic [ch_w(CHANNELS)-1:0]          o_ch,
  output logic [WIDTH-1:0]                   o_data,
  output logic                               o_drop,
  output logic [$clog2(LOG2N_MAX+1)-1:0]     o_log2n
);

  localparam int LW    = $clog2(LOG2N_MAX + 1);
  localparam int CW    = ch_w(CHANNELS);
  localparam int ACC_W = acc_w(WIDTH, LOG2N_MAX);
  localparam int CNT_W = LOG2N_MAX + 1;

  logic [LW-1:0]    l_q;
  logic [CNT_W-1:0] cnt_q [CHANNELS];
  logic [ACC_W-1:0] acc_q [CHANNELS];
  logic             vld_q;
  logic             drop_q;
  logic [CW-1:0]    ch_q;
  logic [WIDTH-1:0] data_q;

  logic             ch_ok;
  logic             take;
  logic [CW-1:0]    ch_idx;
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0] cnt_cur;
  logic [CNT_W-1:0] cnt_last;
  logic             blk_done;
  logic [LW-1:0]    l_d;
  logic [WIDTH-1:0] mean_d;

  always_comb begin
    ch_ok  = (int'(i_ch) < CHANNELS);
    take   = i_vld && !i_clear && ch_ok;
    ch_idx = ch_ok ? i_ch : '0;
    if (SIGNED != 0) begin
      ext = ACC_W'($signed(i_data));
    end else begin
      ext = ACC_W'(i_data);
    end
    cnt_cur  = cnt_q[ch_idx];
    cnt_last = CNT_W'((1 << l_q) - 1);
    // First sample of a block overwrites whatever sum was left behind.
    acc_d    = (cnt_cur == '0) ? ext : acc_q[ch_idx] + ext;
    blk_done = (cnt_cur == cnt_last);
    l_d      = LW'(clamp_log2n(int'(i_log2n), LOG2N_MAX));
  end

  mean_round_shift #(
    .WIDTH     (WIDTH),
    .ACC_W     (ACC_W),
    .LOG2N_MAX (LOG2N_MAX),
    .SIGNED    (SIGNED),
    .ROUND     (ROUND)
  ) u_round_shift (
    .total_i (acc_d),
    .log2n_i (l_q),
    .mean_o  (mean_d)
  );

  always_ff @(posedge clk) begin
    if (take && rstn) begin
      acc_q[ch_idx] <= acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      l_q    <= l_d;
      vld_q  <= 1'b0;
      drop_q <= 1'b0;
      ch_q   <= '0;
      data_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      vld_q  <= 1'b0;
      drop_q <= 1'b0;
      if (i_clear) begin
        l_q <= l_d;
        for (int c = 0; c < CHANNELS; c++) begin
          cnt_q[c] <= '0;
        end
      end else if (i_vld && !ch_ok) begin
        drop_q <= 1'b1;
      end else if (take) begin
        if (blk_done) begin
          cnt_q[ch_idx] <= '0;
          vld_q         <= 1'b1;
          ch_q          <= ch_idx;
          data_q        <= mean_d;
        end else begin
          cnt_q[ch_idx] <= cnt_cur + 1'b1;
        end
      end
    end
  end

  assign o_vld   = vld_q;
  assign o_ch    = ch_q;
  assign o_data  = data_q;
  assign o_drop  = drop_q;
  assign o_log2n = l_q;

endmodule

// File: tb/tb_block_mean_mc.sv
// Two averagers on shared stimulus: rounding with 4 channels, truncating with 3 channels.
module tb_block_mean_mc;

  localparam int W  = 16;
  localparam int LM = 4;
  localparam int LW = 3;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [LW-1:0] i_log2n = 3'd2;
  logic          i_clear = 1'b0;
  logic          i_vld = 1'b0;
  logic [CW-1:0] i_ch = '0;
  logic [W-1:0]  i_data = '0;

  logic          r_vld, r_drop, t_vld, t_drop;
  logic [CW-1:0] r_ch, t_ch;
  logic [W-1:0]  r_data, t_data;
  logic [LW-1:0] r_l, t_l;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {int ch; int d; int at;} ent_t;
  ent_t qr[$];
  ent_t qt[$];
  int   qd[$];

  block_mean_mc #(.WIDTH(W), .CHANNELS(4), .LOG2N_MAX(LM), .SIGNED(1), .ROUND(1)) u_rnd (
    .clk(clk), .rstn(rstn), .i_log2n(i_log2n), .i_clear(i_clear), .i_vld(i_vld),
    .i_ch(i_ch), .i_data(i_data), .o_vld(r_vld), .o_ch(r_ch), .o_data(r_data),
    .o_drop(r_drop), .o_log2n(r_l));

  block_mean_mc #(.WIDTH(W), .CHANNELS(3), .LOG2N_MAX(LM), .SIGNED(1), .ROUND(0)) u_trc (
    .clk(clk), .rstn(rstn), .i_log2n(i_log2n), .i_clear(i_clear), .i_vld(i_vld),
    .i_ch(i_ch), .i_data(i_data), .o_vld(t_vld), .o_ch(t_ch), .o_data(t_data),
    .o_drop(t_drop), .o_log2n(t_l));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
  endtask

  function automatic void push_r(input int ch, input int d);
    qr.push_back('{ch, d & 'hFFFF, cyc + 1});
  endfunction

  function automatic void push_t(input int ch, input int d);
    qt.push_back('{ch, d & 'hFFFF, cyc + 1});
  endfunction

  function automatic void push_both(input int ch, input int dr, input int dt);
    push_r(ch, dr);
    push_t(ch, dt);
  endfunction

  always @(negedge clk) begin : monitor
    ent_t e;
    int   at;
    if (r_vld) begin
      if (qr.size() == 0) flag("rnd_vld");
      else begin
        e = qr.pop_front();
        chk("rnd_ch", int'(r_ch), e.ch);
        chk("rnd_data", int'(r_data), e.d);
        chk("rnd_latency", cyc, e.at);
      end
    end
    if (t_vld) begin
      if (qt.size() == 0) flag("trc_vld");
      else begin
        e = qt.pop_front();
        chk("trc_ch", int'(t_ch), e.ch);
        chk("trc_data", int'(t_data), e.d);
        chk("trc_latency", cyc, e.at);
      end
    end
    if (r_drop) flag("rnd_drop");
    if (t_drop) begin
      if (qd.size() == 0) flag("trc_drop");
      else begin
        at = qd.pop_front();
        chk("trc_drop_latency", cyc, at);
      end
    end
  end

  task automatic smp(input int ch, input int d);
    @(negedge clk);
    i_clear = 1'b0;
    i_vld   = 1'b1;
    i_ch    = CW'(ch);
    i_data  = W'(d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_vld   = 1'b0;
      i_clear = 1'b0;
    end
  endtask

  task automatic clr(input int l, input bit v, input int d);
    @(negedge clk);
    i_clear = 1'b1;
    i_log2n = LW'(l);
    i_vld   = v;
    i_ch    = '0;
    i_data  = W'(d);
  endtask

  task automatic chk_idle_outputs(input string tag, input int l);
    chk({tag, "_rnd_vld"}, int'(r_vld), 0);
    chk({tag, "_rnd_drop"}, int'(r_drop), 0);
    chk({tag, "_rnd_ch"}, int'(r_ch), 0);
    chk({tag, "_rnd_data"}, int'(r_data), 0);
    chk({tag, "_rnd_log2n"}, int'(r_l), l);
    chk({tag, "_trc_vld"}, int'(t_vld), 0);
    chk({tag, "_trc_drop"}, int'(t_drop), 0);
    chk({tag, "_trc_ch"}, int'(t_ch), 0);
    chk({tag, "_trc_data"}, int'(t_data), 0);
    chk({tag, "_trc_log2n"}, int'(t_l), l);
  endtask

  initial begin
    // Reset state with L=2 requested
    idle(3);
    chk_idle_outputs("reset", 2);
    rstn = 1'b1;

    // L=2, ch0 1,2,3,4: 10/4 -> 3 rounded, 2 truncated
    smp(0, 1); smp(0, 2); smp(0, 3);
    smp(0, 4); push_both(0, 3, 2);

    // Interleaved ch0 {8..} and ch1 {-4,-4,-4,-5}: -17 -> -4 rounded, -5 truncated
    smp(0, 8); smp(1, -4); smp(0, 8); smp(1, -4); smp(0, 8); smp(1, -4);
    smp(0, 8);  push_both(0, 8, 8);
    smp(1, -5); push_both(1, -4, -5);

    // L=0: every sample is its own block, back-to-back results
    clr(0, 1'b0, 0); idle(1);
    chk("l0_rnd_log2n", int'(r_l), 0);
    chk("l0_trc_log2n", int'(t_l), 0);
    smp(2, 7);   push_both(2, 7, 7);
    smp(2, -1);  push_both(2, -1, -1);
    smp(2, 300); push_both(2, 300, 300);

    // Clear mid-block with a sample present: sample discarded, L reloaded to 1
    clr(2, 1'b0, 0);
    smp(0, 5); smp(0, 5); smp(0, 5);
    clr(1, 1'b1, 50); idle(1);
    chk("clr_rnd_log2n", int'(r_l), 1);
    chk("clr_trc_log2n", int'(t_l), 1);
    smp(0, 100);
    smp(0, 101); push_both(0, 101, 100);

    // Out-of-range request clamps to LOG2N_MAX
    clr(7, 1'b0, 0); idle(1);
    chk("clamp_rnd_log2n", int'(r_l), LM);
    chk("clamp_trc_log2n", int'(t_l), LM);

    // L=4 full-scale sums do not overflow
    for (int i = 0; i < 16; i++) begin
      smp(2, 'h7FFF);
      if (i == 15) push_both(2, 'h7FFF, 'h7FFF);
    end
    for (int i = 0; i < 16; i++) begin
      smp(2, -32768);
      if (i == 15) push_both(2, 'h8000, 'h8000);
    end

    // L=1: a result already due is still emitted across a clear
    clr(1, 1'b0, 0);
    smp(0, 6);
    smp(0, 8); push_both(0, 7, 7);
    clr(1, 1'b1, 99);

    // ch3 is dropped by the 3-channel instance and accumulated by the other
    smp(0, 10);
    smp(3, 9);  qd.push_back(cyc + 1);
    smp(0, 20); push_both(0, 15, 15);
    smp(3, 11); push_r(3, 10); qd.push_back(cyc + 1);

    // Reset mid-block: outputs zero, the next block starts fresh
    smp(1, 1000);
    @(negedge clk);
    i_vld = 1'b0;
    rstn  = 1'b0;
    @(negedge clk);
    chk_idle_outputs("midrst", 1);
    rstn = 1'b1;
    smp(1, 2);
    smp(1, 4); push_both(1, 3, 3);

    idle(10);
    chk("rnd_pending", qr.size(), 0);
    chk("trc_pending", qt.size(), 0);
    chk("drop_pending", qd.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
